// File: rtl/zuse_seq.sv
// zuse_seq: free-running three-phase pulse generator (a -> b -> c -> a).
//   After reset release the outputs stay low for START_DLY cycles. Each
//   output is then held high for PHASE_LEN cycles, and every phase is
//   followed by GAP_LEN all-low cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   a,b,c - mutually exclusive phase pulses, driven straight from flops
module zuse_seq #(
  parameter int unsigned START_DLY = 2,
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic a,
  output logic b,
  output logic c
);

  if (PHASE_LEN < 1) begin : g_bad_phase_len
    $error("zuse_seq: PHASE_LEN must be at least 1");
  end

  localparam int unsigned MAX_A  = (START_DLY > PHASE_LEN) ? START_DLY : PHASE_LEN;
  localparam int unsigned MAX_V  = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
  localparam int unsigned CNT_W  = ($clog2(MAX_V + 1) > 1) ? $clog2(MAX_V + 1) : 1;
  // Last counter value in each state. Underflow is guarded for the zero cases.
  localparam int unsigned PH_LAST  = (PHASE_LEN > 0) ? PHASE_LEN - 1 : 0;
  localparam int unsigned GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  typedef enum logic [2:0] {
    STARTUP = 3'd0,
    PH_A    = 3'd1,
    GAP_A   = 3'd2,
    PH_B    = 3'd3,
    GAP_B   = 3'd4,
    PH_C    = 3'd5,
    GAP_C   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_q, b_q, c_q;

  // Next state. Every state counts edges and leaves when the count reaches its last value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      STARTUP: if (cnt_q == CNT_W'(START_DLY)) state_d = PH_A;
      PH_A:    if (cnt_q == CNT_W'(PH_LAST))   state_d = (GAP_LEN == 0) ? PH_B : GAP_A;
      GAP_A:   if (cnt_q == CNT_W'(GAP_LAST))  state_d = PH_B;
      PH_B:    if (cnt_q == CNT_W'(PH_LAST))   state_d = (GAP_LEN == 0) ? PH_C : GAP_B;
      GAP_B:   if (cnt_q == CNT_W'(GAP_LAST))  state_d = PH_C;
      PH_C:    if (cnt_q == CNT_W'(PH_LAST))   state_d = (GAP_LEN == 0) ? PH_A : GAP_C;
      GAP_C:   if (cnt_q == CNT_W'(GAP_LAST))  state_d = PH_A;
      default: state_d = STARTUP;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter and output flops. Outputs are decoded from the next state
  // so that they change on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STARTUP;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= (state_d == PH_A);
      b_q     <= (state_d == PH_B);
      c_q     <= (state_d == PH_C);
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;

endmodule

// File: tb/tb_zuse_seq.sv
// Bench for zuse_seq: default configuration plus a tight
// (START_DLY=0, PHASE_LEN=1, GAP_LEN=0) instance sharing clock and reset.
module tb_zuse_seq;

  localparam int SD0 = 2, PL0 = 4, GL0 = 1;
  localparam int SD1 = 0, PL1 = 1, GL1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a0, b0, c0;
  logic a1, b1, c1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  zuse_seq #(.START_DLY(SD0), .PHASE_LEN(PL0), .GAP_LEN(GL0)) u_dut_def (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .c(c0)
  );

  zuse_seq #(.START_DLY(SD1), .PHASE_LEN(PL1), .GAP_LEN(GL1)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {a,b,c} after edge k (k>=1) counted from reset release.
  function automatic logic [2:0] model_abc(input int k, input int sd, input int pl, input int gl);
    int t, per, ph;
    if (k <= sd) return 3'b000;
    per = pl + gl;
    t   = (k - sd - 1) % (3 * per);
    ph  = t / per;
    if ((t % per) >= pl) return 3'b000;
    case (ph)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic onehot0(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  // Run n edges after a release; each edge pushes its expectation before the
  // edge and pops it at the following falling edge.
  task automatic run_edges(input int n, input string tag);
    logic [5:0] e;
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back({model_abc(k, SD0, PL0, GL0), model_abc(k, SD1, PL1, GL1)});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s_def_e%0d", tag, k), 32'({a0, b0, c0}), 32'(e[5:3]));
      check_eq($sformatf("%s_min_e%0d", tag, k), 32'({a1, b1, c1}), 32'(e[2:0]));
      check_eq($sformatf("%s_oh_def_e%0d", tag, k), 32'(onehot0({a0, b0, c0})), 32'd1);
      check_eq($sformatf("%s_oh_min_e%0d", tag, k), 32'(onehot0({a1, b1, c1})), 32'd1);
    end
  endtask

  task automatic hold_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_def_%0d", tag, i), 32'({a0, b0, c0}), 32'd0);
      check_eq($sformatf("%s_min_%0d", tag, i), 32'({a1, b1, c1}), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_eq("por_def", 32'({a0, b0, c0}), 32'd0);
    check_eq("por_min", 32'({a1, b1, c1}), 32'd0);
    hold_reset(10, "rst_hold");

    // Release away from the rising edge; next rising edge is edge 1.
    rst_n = 1'b1;
    run_edges(105, "run1");

    // Restart, then stop inside phase B (edge 9) with an asynchronous reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    hold_reset(2, "rst2");
    rst_n = 1'b1;
    run_edges(9, "pre_b");
    check_eq("b_high_e9", 32'(b0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_def", 32'({a0, b0, c0}), 32'd0);
    check_eq("async_min", 32'({a1, b1, c1}), 32'd0);
    hold_reset(10, "rst_mid");

    rst_n = 1'b1;
    run_edges(40, "run2");

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/zuse_seq.md
Name: zuse_seq

Overview:
- Free-running three-phase sequence generator.
- Drives outputs a, b, c as mutually exclusive, non-overlapping pulses in the fixed order a → b → c → a.
- Each pulse lasts a programmable number of cycles, with an optional all-low dead gap between pulses.
- Has no data inputs. Used as a self-contained stimulus/phase source for downstream sample logic.

Parameters:
- START_DLY, 2: cycles all outputs stay low after reset release before the first a pulse; legal range ≥ 0.
- PHASE_LEN, 4: cycles each output is held high per phase; legal range ≥ 1.
- GAP_LEN, 1: all-low cycles inserted after every phase; legal range ≥ 0.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  output  1  phase-A pulse, registered.
- b  output  1  phase-B pulse, registered.
- c  output  1  phase-C pulse, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): a=b=c=0 immediately. FSM goes to STARTUP; cycle counter cleared. Held for as long as rst_n is low.
- Edge numbering: edge 1 is the first rising clk edge with rst_n=1.
- FSM states: STARTUP, PH_A, GAP_A, PH_B, GAP_B, PH_C, GAP_C.
- STARTUP:
  - Outputs 0 for START_DLY edges.
  - At edge START_DLY+1, enter PH_A and set a=1.
  - START_DLY=0: a rises at edge 1.
- PH_x:
  - Output x=1, others 0, for exactly PHASE_LEN consecutive edges.
  - Then go to GAP_x, or directly to the next phase if GAP_LEN=0.
- GAP_x:
  - All outputs 0 for exactly GAP_LEN edges.
  - Then go to the next phase: A→B, B→C, C→A.
- Period after startup: 3·(PHASE_LEN+GAP_LEN) cycles. STARTUP is never revisited except through reset.
- GAP_LEN=0: handoff happens on a single edge. The old output falls and the new one rises on the same edge; the outputs are never both high.
- Invariant: at most one of a, b, c is high in any cycle (onehot0), including the reset edge and the transitions around it.
- Counter:
  - Width $clog2(max(START_DLY, PHASE_LEN, GAP_LEN)+1), minimum 1 bit.
  - Cleared on every state change; never wraps within a state.
- Outputs are driven directly from flops; no combinational path from rst_n or state decode to a/b/c except the asynchronous clear.
- Reset mid-operation (any state, any counter value): outputs 0 at once. After release, the sequence restarts from STARTUP exactly as after power-up, with no residual phase memory.
- Illegal states (unreachable encodings) recover to STARTUP on the next edge with outputs 0.
- Parameter legality: PHASE_LEN<1 is illegal. The implementation flags it at elaboration (generate-time error or simulation $error).

Test Plan:
- Defaults (START_DLY=2, PHASE_LEN=4, GAP_LEN=1), release rst_n → abc=000 after edges 1–2; a=1 after edges 3–6; 000 after 7; b=1 after 8–11; 000 after 12; c=1 after 13–16; 000 after 17; a=1 again after edge 18 (period 15).
- Defaults, run ≥ 100 cycles → onehot0(a,b,c) holds every cycle; every high pulse is exactly 4 cycles; every gap is exactly 1 cycle.
- GAP_LEN=0, PHASE_LEN=1, START_DLY=0 → a, b, c each high for one cycle in rotation after edges 1, 2, 3, 4(a)…; never two high at once.
- Defaults, assert rst_n low between clock edges while b=1 (edge 9) → b falls asynchronously before the next edge. After release, a rises at edge 3 of the new count.
- Hold rst_n low for 10 cycles with clk running → abc=000 throughout; normal sequence resumes from STARTUP after release.
